p405s_icu_ram_parity_array_gen: RTL and testbench

- Parametrised next-generation ICU parity array: single-port parity RAM wrapper with per-bit write enables and a read-data hold register.
- Adds three things the fixed 512x8 array does not have: a hardware init sweep after reset and on request, a busy indication, and generic width/depth.
- Sits between the ICU array control (index/parity generation) and the SRAM macro; the BIST port overrides the functional path.

---
 rtl/p405s_icu_ram_parity_array_gen_pkg.sv | 22 ++
 rtl/p405s_icu_ram_parity_array_gen_if.sv | 52 +++++
 rtl/p405s_icu_ram_parity_array_gen_sram.sv | 39 +++
 rtl/p405s_icu_ram_parity_array_gen.sv | 157 +++++++++++++++
 tb/tb_p405s_icu_ram_parity_array_gen.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p405s_icu_ram_parity_array_gen_pkg.sv
// ----------------------------------------------------------------------------
// p405s_icu_pkg
// Shared definitions for the parametrised ICU parity array.
//   ICU_PAR_NBITS    : default parity bits per word (one per data sub-field)
//   ICU_PAR_AW       : default parity RAM address width (depth = 2**AW)
//   ICU_PAR_IDXW     : default functional index width
//   ICU_PAR_INIT_VAL : default per-bit value written by the init sweep
//   icuParState_e    : controller state encoding (INIT = 1'b0, IDLE = 1'b1)
// ----------------------------------------------------------------------------
package p405s_icu_pkg;

    localparam int   ICU_PAR_NBITS    = 32'd8;
    localparam int   ICU_PAR_AW       = 32'd9;
    localparam int   ICU_PAR_IDXW     = 32'd10;
    localparam logic ICU_PAR_INIT_VAL = 1'b0;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } icuParState_e;

endpackage : p405s_icu_pkg

// File: rtl/p405s_icu_ram_parity_array_gen_if.sv
// ----------------------------------------------------------------------------
// p405s_icu_ram_parity_array_gen_if
// Functional bus between the ICU array control (master) and the parity
// array (slave).
//   cycleParityRam : access request this cycle
//   readWrParity   : 1 = read, 0 = write
//   dataIndexA     : functional index; only the low address bits are used
//   bitWrite       : per-bit write enable (writes only)
//   parityIn       : write data
//   initReq        : pulse that restarts the init sweep
//   parityOut      : read data, held until the next read returns
//   initBusy       : init sweep in progress, requests are dropped
// ----------------------------------------------------------------------------
interface p405s_icu_ram_parity_array_gen_if
    import p405s_icu_pkg::*;
#(
    parameter int NBITS = ICU_PAR_NBITS,
    parameter int IDXW  = ICU_PAR_IDXW
);

    logic             cycleParityRam;
    logic             readWrParity;
    logic [IDXW-1:0]  dataIndexA;
    logic [NBITS-1:0] bitWrite;
    logic [NBITS-1:0] parityIn;
    logic             initReq;
    logic [NBITS-1:0] parityOut;
    logic             initBusy;

    modport master (
        output cycleParityRam,
        output readWrParity,
        output dataIndexA,
        output bitWrite,
        output parityIn,
        output initReq,
        input  parityOut,
        input  initBusy
    );

    modport slave (
        input  cycleParityRam,
        input  readWrParity,
        input  dataIndexA,
        input  bitWrite,
        input  parityIn,
        input  initReq,
        output parityOut,
        output initBusy
    );

endinterface : p405s_icu_ram_parity_array_gen_if

// File: rtl/p405s_icu_ram_parity_array_gen_sram.sv
// ----------------------------------------------------------------------------
// p405s_icu_sram_gen
// Behavioural single-port RAM with per-bit write enables, synchronous
// 1-cycle read. The read register is left untouched on write cycles.
//   cclk  : clock
//   cen_n : active-low chip enable
//   we    : 1 = write cycle, 0 = read cycle
//   bwe   : per-bit write enable (write cycles only)
//   addr  : word address
//   d     : write data
//   q     : read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module p405s_icu_sram_gen #(
    parameter int NBITS = 32'd8,
    parameter int AW    = 32'd9
) (
    input  logic             cclk,
    input  logic             cen_n,
    input  logic             we,
    input  logic [NBITS-1:0] bwe,
    input  logic [AW-1:0]    addr,
    input  logic [NBITS-1:0] d,
    output logic [NBITS-1:0] q
);

    logic [NBITS-1:0] mem_r [2**AW];

    // Array write with bit merge, or registered read.
    always_ff @(posedge cclk) begin
        if (!cen_n) begin
            if (we) begin
                mem_r[addr] <= (mem_r[addr] & ~bwe) | (d & bwe);
            end else begin
                q <= mem_r[addr];
            end
        end
    end

endmodule : p405s_icu_sram_gen

// File: rtl/p405s_icu_ram_parity_array_gen.sv
// ----------------------------------------------------------------------------
// p405s_icu_ram_parity_array_gen
// Parametrised ICU parity array: single-port parity RAM wrapper with
// per-bit write enables, read-data hold register and a hardware init sweep
// after reset or on initReq.
//   CB               : clock, all state on the rising edge
//   resetN           : synchronous active-low reset
//   bus              : functional bus (slave side), see the interface file
//   bist_mode        : BIST owns the RAM port (highest priority)
//   bist_ce_n/we_n   : BIST active-low chip/write enable
//   bist_addr        : BIST address
//   bist_wr_data     : BIST write data
//   bist_rd_data     : RAM read register, visible in every mode
//   cap_mem_addr     : final muxed RAM address
//   cap_mem_wr_data  : final muxed RAM write data
//   cap_mem_we       : final muxed RAM write enable
// Port priority: bist_mode > init sweep > functional access.
// ----------------------------------------------------------------------------
module p405s_icu_ram_parity_array_gen
    import p405s_icu_pkg::*;
#(
    parameter int   NBITS    = ICU_PAR_NBITS,
    parameter int   AW       = ICU_PAR_AW,
    parameter int   IDXW     = ICU_PAR_IDXW,
    parameter logic INIT_VAL = ICU_PAR_INIT_VAL
) (
    input  logic                 CB,
    input  logic                 resetN,
    p405s_icu_ram_parity_array_gen_if.slave bus,
    input  logic                 bist_mode,
    input  logic                 bist_ce_n,
    input  logic                 bist_we_n,
    input  logic [AW-1:0]        bist_addr,
    input  logic [NBITS-1:0]     bist_wr_data,
    output logic [NBITS-1:0]     bist_rd_data,
    output logic [AW-1:0]        cap_mem_addr,
    output logic [NBITS-1:0]     cap_mem_wr_data,
    output logic                 cap_mem_we
);

    icuParState_e     state_r;
    logic [AW-1:0]    initAddr_r;
    logic             rdPend_r;
    logic [NBITS-1:0] hold_r;

    logic             ramCenN_s;
    logic             ramWe_s;
    logic [NBITS-1:0] ramBwe_s;
    logic [AW-1:0]    ramAddr_s;
    logic [NBITS-1:0] ramD_s;
    logic [NBITS-1:0] ramQ_s;
    logic             funcRd_s;
    logic [AW-1:0]    funcAddr_s;
    logic             unusedIdxBits_s;

    // The index is numbered big-endian upstream; its last AW bits are the
    // numerically low bits, so the RAM address is simply the low slice.
    assign funcAddr_s      = bus.dataIndexA[AW-1:0];
    assign unusedIdxBits_s = ^bus.dataIndexA[IDXW-1:AW];

    // RAM port mux: BIST, then init sweep, then functional requests.
    always_comb begin
        ramCenN_s = 1'b1;
        ramWe_s   = 1'b0;
        ramBwe_s  = {NBITS{1'b0}};
        ramAddr_s = {AW{1'b0}};
        ramD_s    = {NBITS{1'b0}};
        funcRd_s  = 1'b0;
        if (bist_mode) begin
            ramCenN_s = bist_ce_n;
            ramWe_s   = ~bist_we_n;
            ramBwe_s  = {NBITS{1'b1}};
            ramAddr_s = bist_addr;
            ramD_s    = bist_wr_data;
        end else if (!resetN) begin
            // No sweep or functional access while reset is applied, so a
            // stale sweep address cannot be written during reset.
            ramCenN_s = 1'b1;
        end else if (state_r == INIT) begin
            ramCenN_s = 1'b0;
            ramWe_s   = 1'b1;
            ramBwe_s  = {NBITS{1'b1}};
            ramAddr_s = initAddr_r;
            ramD_s    = {NBITS{INIT_VAL}};
        end else if (bus.cycleParityRam) begin
            ramCenN_s = 1'b0;
            ramWe_s   = ~bus.readWrParity;
            ramBwe_s  = bus.readWrParity ? {NBITS{1'b0}} : bus.bitWrite;
            ramAddr_s = funcAddr_s;
            ramD_s    = bus.parityIn;
            funcRd_s  = bus.readWrParity;
        end else begin
            ramCenN_s = 1'b1;
        end
    end

    p405s_icu_sram_gen #(
        .NBITS (NBITS),
        .AW    (AW)
    ) u_sram (
        .cclk  (CB),
        .cen_n (ramCenN_s),
        .we    (ramWe_s),
        .bwe   (ramBwe_s),
        .addr  (ramAddr_s),
        .d     (ramD_s),
        .q     (ramQ_s)
    );

    // Init-sweep controller, read-pending flag and read-data hold register.
    always_ff @(posedge CB) begin
        if (!resetN) begin
            state_r    <= INIT;
            initAddr_r <= {AW{1'b0}};
            rdPend_r   <= 1'b0;
            hold_r     <= {NBITS{1'b0}};
        end else begin
            // funcRd_s is already low whenever BIST or the sweep owns the port.
            rdPend_r <= funcRd_s;
            if (rdPend_r) begin
                hold_r <= ramQ_s;
            end
            case (state_r)
                INIT: begin
                    if (bus.initReq) begin
                        initAddr_r <= {AW{1'b0}};
                    end else if (!bist_mode) begin
                        initAddr_r <= initAddr_r + {{(AW-1){1'b0}}, 1'b1};
                        // Terminal count on all-ones: the last address is
                        // written this cycle, so the sweep is complete.
                        if (initAddr_r == {AW{1'b1}}) begin
                            state_r <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (bus.initReq) begin
                        state_r    <= INIT;
                        initAddr_r <= {AW{1'b0}};
                    end
                end
                default: begin
                    state_r    <= INIT;
                    initAddr_r <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign bus.parityOut   = rdPend_r ? ramQ_s : hold_r;
    assign bus.initBusy    = (state_r == INIT);
    assign bist_rd_data    = ramQ_s;
    assign cap_mem_addr    = ramAddr_s;
    assign cap_mem_wr_data = ramD_s;
    assign cap_mem_we      = ~ramCenN_s & ramWe_s;

endmodule : p405s_icu_ram_parity_array_gen

// File: tb/tb_p405s_icu_ram_parity_array_gen.sv
// ----------------------------------------------------------------------------
// tb_p405s_icu_ram_parity_array_gen
// Scoreboard bench: stimulus pushes expected read data (from a plain array
// model of the parity RAM) into queues; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_p405s_icu_ram_parity_array_gen;

    logic       CB = 1'b0;
    logic       resetN;
    logic       bist_mode;
    logic       bist_ce_n;
    logic       bist_we_n;
    logic [8:0] bist_addr;
    logic [7:0] bist_wr_data;
    logic [7:0] bist_rd_data;
    logic [8:0] cap_mem_addr;
    logic [7:0] cap_mem_wr_data;
    logic       cap_mem_we;

    p405s_icu_ram_parity_array_gen_if #(.NBITS(8), .IDXW(10)) bus ();

    p405s_icu_ram_parity_array_gen dut (
        .CB              (CB),
        .resetN          (resetN),
        .bus             (bus),
        .bist_mode       (bist_mode),
        .bist_ce_n       (bist_ce_n),
        .bist_we_n       (bist_we_n),
        .bist_addr       (bist_addr),
        .bist_wr_data    (bist_wr_data),
        .bist_rd_data    (bist_rd_data),
        .cap_mem_addr    (cap_mem_addr),
        .cap_mem_wr_data (cap_mem_wr_data),
        .cap_mem_we      (cap_mem_we)
    );

    always #5 CB = ~CB;

    typedef struct {
        int         due;
        logic [7:0] data;
    } expT;

    expT        rdQ[$];
    expT        bistQ[$];
    logic [7:0] model [512];
    int         edges   = 0;
    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] expHold = 8'h00;

    always @(posedge CB) edges <= edges + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: parityOut must track the last returned read; BIST reads due now.
    always @(negedge CB) begin
        if (edges >= 1) begin
            if (rdQ.size() > 0 && rdQ[0].due == edges) begin
                expHold = rdQ[0].data;
                void'(rdQ.pop_front());
            end
            check8("parityOut", bus.parityOut, expHold);
            if (bistQ.size() > 0 && bistQ[0].due == edges) begin
                check8("bist_rd_data", bist_rd_data, bistQ[0].data);
                void'(bistQ.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge CB);
        #1;
    endtask

    task automatic pushRd(input logic [7:0] d);
        expT e;
        e.due  = edges + 1;
        e.data = d;
        rdQ.push_back(e);
    endtask

    task automatic clearModel;
        for (int i = 0; i < 512; i++) model[i] = 8'h00;
    endtask

    task automatic idle(input int k);
        bus.cycleParityRam = 1'b0;
        bus.initReq        = 1'b0;
        repeat (k) tick();
    endtask

    task automatic doWrite(input int idx, input logic [7:0] d, input logic [7:0] m);
        logic [9:0] ix;
        ix = idx[9:0];
        bus.cycleParityRam = 1'b1;
        bus.readWrParity   = 1'b0;
        bus.dataIndexA     = ix;
        bus.bitWrite       = m;
        bus.parityIn       = d;
        model[idx % 512]   = (model[idx % 512] & ~m) | (d & m);
        tick();
    endtask

    task automatic doRead(input int idx);
        logic [9:0] ix;
        ix = idx[9:0];
        bus.cycleParityRam = 1'b1;
        bus.readWrParity   = 1'b1;
        bus.dataIndexA     = ix;
        bus.bitWrite       = 8'h00;
        pushRd(model[idx % 512]);
        tick();
    endtask

    task automatic bistOp(input logic wr, input int a, input logic [7:0] d);
        expT e;
        bus.cycleParityRam = 1'b0;
        bist_mode    = 1'b1;
        bist_ce_n    = 1'b0;
        bist_we_n    = ~wr;
        bist_addr    = a[8:0];
        bist_wr_data = d;
        if (wr) begin
            model[a % 512] = d;
        end else begin
            e.due  = edges + 1;
            e.data = model[a % 512];
            bistQ.push_back(e);
        end
        tick();
        bist_mode = 1'b0;
        bist_ce_n = 1'b1;
        bist_we_n = 1'b1;
    endtask

    task automatic doReset;
        bus.cycleParityRam = 1'b0;
        bus.initReq        = 1'b0;
        resetN = 1'b0;
        pushRd(8'h00);
        tick();
        tick();
        resetN = 1'b1;
    endtask

    // Count cycles with initBusy high; optional BIST burst, dropped-request
    // probe and early stop at given cycle counts.
    task automatic runSweep(input int bistAt, input int probeAt, input int stopAt, output int n);
        n = 0;
        while (bus.initBusy === 1'b1 && n < 3000 && n != stopAt) begin
            if (n == bistAt) begin
                bistOp(1'b1, 511, 8'h5A);
                bistOp(1'b0, 511, 8'h00);
                n += 2;
                bist_mode = 1'b1;
                bist_ce_n = 1'b1;
                repeat (18) begin
                    tick();
                    n++;
                end
                bist_mode = 1'b0;
                #1;
                checkInt("sweep resume addr", cap_mem_addr, bistAt);
            end
            if (n == probeAt) begin
                bus.cycleParityRam = 1'b1;
                bus.readWrParity   = 1'b1;
                bus.dataIndexA     = 10'h005;
                #1;
                checkInt("dropped req addr", cap_mem_addr, n);
                check8("dropped req data", cap_mem_wr_data, 8'h00);
                checkInt("dropped req we", cap_mem_we, 1);
            end
            n++;
            tick();
            bus.cycleParityRam = 1'b0;
        end
    endtask

    initial begin
        int n;
        int op;
        int a;
        logic [7:0] d;
        logic [7:0] m;
        bus.cycleParityRam = 1'b0;
        bus.readWrParity   = 1'b0;
        bus.dataIndexA     = 10'h000;
        bus.bitWrite       = 8'h00;
        bus.parityIn       = 8'h00;
        bus.initReq        = 1'b0;
        bist_mode    = 1'b0;
        bist_ce_n    = 1'b1;
        bist_we_n    = 1'b1;
        bist_addr    = 9'h000;
        bist_wr_data = 8'h00;
        resetN       = 1'b0;

        // Power-up sweep, then every address reads the init value.
        doReset();
        checkInt("busy after reset", bus.initBusy, 1);
        runSweep(-1, -1, -1, n);
        checkInt("init sweep cycles", n, 512);
        clearModel();
        for (int i = 0; i < 512; i++) doRead(i);
        idle(2);

        // Masked write.
        doWrite(10'h005, 8'hFF, 8'hFF);
        doWrite(10'h005, 8'h00, 8'h0F);
        doRead(10'h005);
        // Hold across idles and a write.
        idle(1);
        doRead(10'h005);
        idle(10);
        doWrite(10'h006, 8'hAA, 8'hFF);
        idle(3);
        // Index MSB ignored, back-to-back reads.
        doWrite(10'h205, 8'h3C, 8'hFF);
        doRead(10'h005);
        doRead(10'h005);
        doRead(10'h006);
        // Zero mask writes nothing.
        doWrite(10'h006, 8'h55, 8'h00);
        doRead(10'h006);
        idle(2);

        // initReq in IDLE wipes contents; a request during busy is dropped.
        doWrite(10'h010, 8'h77, 8'hFF);
        doRead(10'h010);
        idle(2);
        bus.initReq = 1'b1;
        tick();
        bus.initReq = 1'b0;
        runSweep(-1, 50, -1, n);
        checkInt("initReq sweep cycles", n, 512);
        clearModel();
        doRead(10'h010);
        idle(2);

        // Reset mid-sweep restarts from zero.
        bus.initReq = 1'b1;
        tick();
        bus.initReq = 1'b0;
        runSweep(-1, -1, 200, n);
        checkInt("partial sweep", n, 200);
        doReset();
        runSweep(-1, -1, -1, n);
        checkInt("sweep after mid reset", n, 512);
        clearModel();

        // BIST override during the sweep.
        doReset();
        runSweep(100, -1, -1, n);
        checkInt("sweep with bist cycles", n, 532);
        clearModel();
        doRead(10'h1FF);
        idle(2);

        // Randomised functional and BIST traffic in IDLE.
        for (int k = 0; k < 500; k++) begin
            op = $urandom_range(0, 4);
            a  = $urandom_range(0, 15) + 512 * $urandom_range(0, 1);
            d  = 8'($urandom_range(0, 255));
            m  = 8'($urandom_range(0, 255));
            case (op)
                0, 1: doWrite(a, d, m);
                2:    doRead(a);
                3:    idle($urandom_range(1, 2));
                default: bistOp($urandom_range(0, 1) == 1, a % 16, d);
            endcase
        end
        idle(5);
        checkInt("read queue drained", rdQ.size(), 0);
        checkInt("bist queue drained", bistQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_p405s_icu_ram_parity_array_gen
